// File: rtl/fifo_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter_pkg
//  Purpose  : Shared types, defaults and width helpers for the FIFO write
//             arbiter and the FIFO instance it feeds.
//  Revision : 1.0  initial release
// ============================================================================
package fifo_wr_arbiter_pkg;

  // Defaults shared with the FIFO instance.
  localparam int c_def_width = 8;
  localparam int c_def_n     = 4;
  localparam int c_def_burst = 4;

  // Arbiter mode: no burst in progress, or owner is mid-burst.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_mode_e;

  // Width of an index into N requesters (at least one bit).
  function automatic int f_owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must hold the value BURST.
  function automatic int f_cnt_w(input int burst);
    return (burst > 0) ? $clog2(burst + 1) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter_if
//  Purpose  : Producer request/grant bundle plus the FIFO write port.
//             slave  = arbiter side, master = producers/FIFO side.
//  Revision : 1.0  initial release
// ============================================================================
interface fifo_wr_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] req_data;
  logic [N-1:0]       gnt;
  logic               fifo_full;
  logic               fifo_wr_en;
  logic [WIDTH-1:0]   fifo_wr_data;

  modport slave (
    input  req, req_data, fifo_full,
    output gnt, fifo_wr_en, fifo_wr_data
  );

  modport master (
    output req, req_data, fifo_full,
    input  gnt, fifo_wr_en, fifo_wr_data
  );
endinterface
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_priority_pick
//  Purpose  : Combinational rotating priority encoder. Returns the first set
//             request searching start, start+1, ... modulo N.
//  Revision : 1.0  initial release
// ============================================================================
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] pick_idx,
  output logic          any
);

  int            w_idx;
  logic [IW-1:0] w_sel;

  // Walk the requests from start with wrap-around; the first hit wins.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    w_idx    = 0;
    w_sel    = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = int'(start) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      w_sel = w_idx[IW-1:0];
      if (!any && req[w_sel]) begin
        any         = 1'b1;
        pick_idx    = w_sel;
        pick[w_sel] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter
//  Purpose  : Shares one FIFO write port among N producers using round-robin
//             with bounded bursts. Zero-latency grant, never writes on full.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int WIDTH = c_def_width,
  parameter int N     = c_def_n,
  parameter int BURST = c_def_burst
) (
  input  logic              clk,
  input  logic              rst,
  fifo_wr_arbiter_if.slave  bus
);

  localparam int              c_ow    = f_owner_w(N);
  localparam int              c_cw    = f_cnt_w(BURST);
  localparam logic [c_ow-1:0] c_last  = c_ow'(N - 1);
  localparam logic [c_cw-1:0] c_burst = c_cw'(BURST);

  logic [c_ow-1:0] r_owner, w_owner_nxt;
  logic [c_cw-1:0] r_cnt,   w_cnt_nxt;
  arb_mode_e       r_mode,  w_mode_nxt;

  logic [c_ow-1:0] w_start;
  logic [N-1:0]    w_pick;
  logic [c_ow-1:0] w_pick_idx;
  logic            w_any;
  logic            w_hold;
  logic [c_ow-1:0] w_win;
  logic            w_grant;

  // Search begins just after the last owner so the owner itself is last.
  assign w_start = (r_owner == c_last) ? '0 : r_owner + 1'b1;

  rr_priority_pick #(
    .N  (N),
    .IW (c_ow)
  ) u_pick (
    .req      (bus.req),
    .start    (w_start),
    .pick     (w_pick),
    .pick_idx (w_pick_idx),
    .any      (w_any)
  );

  // Burst continuation overrides rotation while the owner has budget left.
  assign w_hold  = (r_mode == HOLD) && bus.req[r_owner] && (r_cnt < c_burst);
  assign w_win   = w_hold ? r_owner : w_pick_idx;
  assign w_grant = (w_hold || w_any) && !bus.fifo_full && !rst;

  // Drive grant and FIFO write port straight from the selection.
  always_comb begin
    bus.gnt          = '0;
    bus.fifo_wr_data = '0;
    bus.fifo_wr_en   = w_grant;
    if (w_grant) begin
      bus.gnt          = w_hold ? (N'(1) << r_owner) : w_pick;
      bus.fifo_wr_data = bus.req_data[int'(w_win)*WIDTH +: WIDTH];
    end
  end

  // Next owner/count/mode; a full FIFO freezes everything so bursts resume.
  always_comb begin
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    w_mode_nxt  = r_mode;
    if (w_grant) begin
      w_mode_nxt = HOLD;
      if ((w_win == r_owner) && (r_cnt < c_burst)) begin
        w_cnt_nxt = r_cnt + 1'b1;
      end else begin
        w_owner_nxt = w_win;
        w_cnt_nxt   = c_cw'(1);
      end
    end else if (!bus.fifo_full && (bus.req == '0)) begin
      w_mode_nxt = IDLE;
      w_cnt_nxt  = '0;
    end
  end

  // State register; reset makes requester 0 the top priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= c_last;
      r_cnt   <= '0;
      r_mode  <= IDLE;
    end else begin
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mode  <= w_mode_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_wr_arbiter
//  Purpose  : Directed vector bench for fifo_wr_arbiter (N=4, WIDTH=8,
//             BURST=4). One vector per clock cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic        full;
    logic [3:0]  egnt;
    logic [7:0]  edata;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vec_t       tbl[$];
  logic [7:0] fq[$];
  int         n_chk  = 0;
  int         n_fail = 0;

  fifo_wr_arbiter_if #(.N(4), .WIDTH(8)) bus ();

  fifo_wr_arbiter #(.WIDTH(8), .N(4), .BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic [3:0] q,
                              input logic [31:0] d, input logic f,
                              input logic [3:0] g, input logic [7:0] e);
    vec_t v;
    v.rst = r; v.req = q; v.data = d; v.full = f; v.egnt = g; v.edata = e;
    tbl.push_back(v);
  endfunction

  function automatic void add_rst();
    add(1'b1, 4'h0, 32'h0, 1'b0, 4'h0, 8'h00);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply each vector after the falling edge, compare before the rising edge.
  task automatic run_tbl(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst           = tbl[i].rst;
      bus.req       = tbl[i].req;
      bus.req_data  = tbl[i].data;
      bus.fifo_full = tbl[i].full;
      #1;
      check($sformatf("%s[%0d] gnt", tag, i), 32'(bus.gnt), 32'(tbl[i].egnt));
      check($sformatf("%s[%0d] wr_en", tag, i), 32'(bus.fifo_wr_en), 32'(|tbl[i].egnt));
      check($sformatf("%s[%0d] wr_data", tag, i), 32'(bus.fifo_wr_data), 32'(tbl[i].edata));
      if (bus.fifo_wr_en === 1'b1) fq.push_back(bus.fifo_wr_data);
    end
    tbl.delete();
  endtask

  initial begin
    bus.req       = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;

    // Reset with all requesting, then requester 0 wins first.
    add(1'b1, 4'hF, 32'h44332211, 1'b0, 4'h0, 8'h00);
    add(1'b1, 4'hF, 32'h44332211, 1'b0, 4'h0, 8'h00);
    add(1'b0, 4'hF, 32'h44332211, 1'b0, 4'h1, 8'h11);
    run_tbl("reset");

    // Single producer, 8 back-to-back words.
    add_rst();
    for (int k = 0; k < 8; k++)
      add(1'b0, 4'h1, {24'h0, 8'((k + 1) * 8'h11)}, 1'b0, 4'h1, 8'((k + 1) * 8'h11));
    fq.delete();
    run_tbl("single");
    check("single count", 32'(fq.size()), 32'd8);
    for (int k = 0; k < 8; k++)
      if (k < fq.size()) check($sformatf("single rd%0d", k), 32'(fq[k]), 32'((k + 1) * 8'h11));

    // Full contention: four-grant bursts in rotation.
    add_rst();
    for (int k = 0; k < 16; k++)
      add(1'b0, 4'hF, 32'hA3A2A1A0, 1'b0, 4'(1 << (k / 4)), 8'(8'hA0 + k / 4));
    fq.delete();
    run_tbl("contend");
    check("contend count", 32'(fq.size()), 32'd16);

    // Stall with requester 2 at cnt=2, then resume with 2 more grants.
    add_rst();
    for (int k = 0; k < 10; k++)
      add(1'b0, 4'hF, 32'hD3D2D1D0, 1'b0, 4'(1 << (k / 4)), 8'(8'hD0 + k / 4));
    add(1'b0, 4'hF, 32'hD3D2D1D0, 1'b1, 4'h0, 8'h00);
    add(1'b0, 4'hF, 32'hD3D2D1D0, 1'b1, 4'h0, 8'h00);
    add(1'b0, 4'hF, 32'hD3D2D1D0, 1'b0, 4'h4, 8'hD2);
    add(1'b0, 4'hF, 32'hD3D2D1D0, 1'b0, 4'h4, 8'hD2);
    add(1'b0, 4'hF, 32'hD3D2D1D0, 1'b0, 4'h8, 8'hD3);
    run_tbl("stall");

    // Early release: owner 1 drops, 3 wins same cycle and starts a fresh burst.
    add_rst();
    add(1'b0, 4'h2, 32'h44332211, 1'b0, 4'h2, 8'h22);
    add(1'b0, 4'h2, 32'h44332211, 1'b0, 4'h2, 8'h22);
    add(1'b0, 4'h8, 32'h44332211, 1'b0, 4'h8, 8'h44);
    for (int k = 0; k < 3; k++)
      add(1'b0, 4'hA, 32'h44332211, 1'b0, 4'h8, 8'h44);
    add(1'b0, 4'hA, 32'h44332211, 1'b0, 4'h2, 8'h22);
    run_tbl("release");

    // Reset mid-burst: first grant afterwards follows reset priority.
    add_rst();
    for (int k = 0; k < 3; k++)
      add(1'b0, 4'h4, 32'h44332211, 1'b0, 4'h4, 8'h33);
    add(1'b1, 4'h5, 32'h44332211, 1'b0, 4'h0, 8'h00);
    add(1'b0, 4'h5, 32'h44332211, 1'b0, 4'h1, 8'h11);
    run_tbl("midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
